// File: rtl/arith_sched_pkg.sv
// Shared types, opcodes and result-select helper for the arithmetic op scheduler.
package arith_sched_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_MUL = 3'd2;
  localparam logic [OP_W-1:0] OP_DIV = 3'd3;
  localparam logic [OP_W-1:0] OP_MOD = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SEL_SUM  = 3'd0,
    SEL_DIFF = 3'd1,
    SEL_PROD = 3'd2,
    SEL_QUOT = 3'd3,
    SEL_REM  = 3'd4,
    SEL_ERR  = 3'd5
  } sel_e;

  // Chooses which datapath output is the answer; zero divisor and unknown opcodes are errors.
  function automatic sel_e result_sel(input logic [OP_W-1:0] op, input logic b_zero);
    sel_e sel;
    sel = SEL_ERR;
    case (op)
      OP_ADD:  sel = SEL_SUM;
      OP_SUB:  sel = SEL_DIFF;
      OP_MUL:  sel = SEL_PROD;
      OP_DIV:  sel = b_zero ? SEL_ERR : SEL_QUOT;
      OP_MOD:  sel = b_zero ? SEL_ERR : SEL_REM;
      default: sel = SEL_ERR;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/arith_rr_arb.sv
// NREQ-way one-hot arbiter. ARITH_OP_SCHEDULER_RR_EN selects round-robin from ptr_i;
// otherwise fixed priority with the lowest index winning.
module arith_rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
`ifdef ARITH_OP_SCHEDULER_RR_EN
  input  logic [IW-1:0]   ptr_i,
`endif
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  logic [IW-1:0] idx;
  logic          found;

  // First requester found in search order wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef ARITH_OP_SCHEDULER_RR_EN
      idx = IW'((32'(ptr_i) + i) % NREQ);
`else
      idx = IW'(i);
`endif
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        idx_o      = idx;
      end
    end
  end

endmodule

// File: rtl/arith_op_scheduler.sv
// Shares one combinational add/sub/mul/div/mod unit among NREQ requesters, one op in flight.
// Build with ARITH_OP_SCHEDULER_RR_EN for round-robin grant; default is fixed priority.
module arith_op_scheduler
  import arith_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  input  logic [NREQ*OP_W-1:0]     req_op,
  output logic [W-1:0]             alu_a,
  output logic [W-1:0]             alu_b,
  input  logic [2*W-1:0]           alu_ym,
  input  logic [W-1:0]             alu_ya,
  input  logic [W-1:0]             alu_ys,
  input  logic [W-1:0]             alu_yd,
  input  logic [W-1:0]             alu_ymod,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [2*W-1:0]           rsp_result,
  output logic                     rsp_err,
  output logic                     busy
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned RW = 2 * W;

  state_e          state_q;
  logic [W-1:0]    alu_a_q, alu_b_q;
  logic [OP_W-1:0] op_q;
  logic [IW-1:0]   id_q;
  logic            rsp_valid_q, rsp_err_q;
  logic [IW-1:0]   rsp_id_q;
  logic [RW-1:0]   rsp_result_q;

  logic [NREQ-1:0] arb_req, gnt;
  logic [IW-1:0]   gnt_idx;
  int unsigned     a_base, op_base;
  sel_e            sel;
  logic [RW-1:0]   res_c;
  logic            err_c;

  // Only arbitrate in IDLE so req_ready is zero while an op is in flight.
  assign arb_req = (state_q == IDLE) ? req_valid : '0;

`ifdef ARITH_OP_SCHEDULER_RR_EN
  logic [IW-1:0] ptr_q;

  arith_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req_i (arb_req),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (|gnt) begin
      ptr_q <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  arith_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req_i (arb_req),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );
`endif

  assign req_ready = gnt;

  always_comb begin
    a_base  = 32'(gnt_idx) * W;
    op_base = 32'(gnt_idx) * OP_W;
  end

  // Pick the datapath output for the latched op; errors force a zero result.
  always_comb begin
    sel   = result_sel(op_q, alu_b_q == '0);
    res_c = '0;
    case (sel)
      SEL_SUM:  res_c = RW'(alu_ya);
      SEL_DIFF: res_c = RW'(alu_ys);
      SEL_PROD: res_c = alu_ym;
      SEL_QUOT: res_c = RW'(alu_yd);
      SEL_REM:  res_c = RW'(alu_ymod);
      default:  res_c = '0;
    endcase
    err_c = (sel == SEL_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      op_q         <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            alu_a_q <= req_a[a_base +: W];
            alu_b_q <= req_b[a_base +: W];
            op_q    <= req_op[op_base +: OP_W];
            id_q    <= gnt_idx;
            state_q <= ISSUE;
          end
        end
        // Datapath has settled on the registered operands by the end of ISSUE.
        ISSUE: begin
          rsp_valid_q  <= 1'b1;
          rsp_result_q <= res_c;
          rsp_err_q    <= err_c;
          rsp_id_q     <= id_q;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != IDLE);

endmodule
